// File: rtl/aq_gemac_pkg.sv
// Shared types and widths for the GEMAC ARP resolution scheduler.
package aq_gemac_pkg;

   localparam int unsigned TIMER_W = 32;
   localparam int unsigned RETRY_W = 4;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned IP_W    = 32;

   // Scheduler states; the encoding is exported on SCHED_STATE for debug.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_GUARD    = 3'd2,
      ST_WAIT     = 3'd3,
      ST_HOLDOFF  = 3'd4,
      ST_RESOLVED = 3'd5,
      ST_FAILED   = 3'd6
   } sched_state_e;

   // Saturating increment of the failed-attempt counter.
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] cnt);
      return (cnt == {RETRY_W{1'b1}}) ? cnt : cnt + RETRY_W'(1);
   endfunction

endpackage

// File: rtl/aq_gemac_arp_timer.sv
// Loadable down-counter shared by the retry hold-off and the refresh period.
module aq_gemac_arp_timer
   import aq_gemac_pkg::*;
(
   input  logic               sys_clk,
   input  logic               RST_N,
   input  logic               load,
   input  logic               en,
   input  logic [TIMER_W-1:0] load_value,
   output logic               zero_c
);

   logic [TIMER_W-1:0] count_q;

   // Load has priority; counting stops at zero.
   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - TIMER_W'(1);
      end
   end

   assign zero_c = (count_q == '0);

endmodule

// File: rtl/aq_gemac_arp_sched.sv
// ARP resolution scheduler: drives ARP-client requests with timed, bounded
// retries and re-resolves on peer IP change.
// Optional build macro AQ_GEMAC_ARP_REFRESH_EN: periodic re-resolution while
// resolved, keeping PEER_RESOLVED high through the refresh attempts.
module aq_gemac_arp_sched
   import aq_gemac_pkg::*;
#(
   parameter logic [TIMER_W-1:0] RETRY_INTERVAL   = 32'd125_000_000,
   parameter logic [RETRY_W-1:0] MAX_RETRY        = 4'd4,
   parameter logic [TIMER_W-1:0] REFRESH_INTERVAL = 32'd1_250_000_000
) (
   input  logic               sys_clk,
   input  logic               RST_N,
   input  logic               ENABLE,
   input  logic [IP_W-1:0]    PEER_IP_ADDRESS,
   input  logic               ARPC_ENABLE,
   input  logic               ARPC_VALID,
   output logic               ARPC_REQUEST,
   output logic               PEER_RESOLVED,
   output logic               ARP_FAIL,
   output logic [RETRY_W-1:0] RETRY_COUNT,
   output logic [STATE_W-1:0] SCHED_STATE
);

`ifdef AQ_GEMAC_ARP_REFRESH_EN
   localparam bit REFRESH_EN = 1'b1;
`else
   localparam bit REFRESH_EN = 1'b0;
`endif

   sched_state_e       state_q, state_d;
   logic [IP_W-1:0]    ip_q;
   logic               abort_pend_q, abort_pend_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [RETRY_W-1:0] retry_inc_c;
   logic               arpc_request_d;
   logic               peer_resolved_d;
   logic               arp_fail_d;
   logic               ip_change_c;
   logic               abort_c;
   logic               discard_c;
   logic               timer_load_c;
   logic               timer_en_c;
   logic [TIMER_W-1:0] timer_load_value_c;
   logic               timer_zero_c;

   // An IP change or a low ENABLE aborts the current resolution.
   assign ip_change_c = (PEER_IP_ADDRESS != ip_q);
   assign abort_c     = ip_change_c | ~ENABLE;
   assign discard_c   = abort_c | abort_pend_q;

   // Hold-off / refresh timer.
   aq_gemac_arp_timer u_timer (
      .sys_clk    (sys_clk),
      .RST_N      (RST_N),
      .load       (timer_load_c),
      .en         (timer_en_c),
      .load_value (timer_load_value_c),
      .zero_c     (timer_zero_c)
   );

   // Next-state, retry bookkeeping and registered-output decode.
   always_comb begin
      state_d            = state_q;
      retry_d            = retry_q;
      abort_pend_d       = abort_pend_q;
      retry_inc_c        = retry_inc(retry_q);
      arpc_request_d     = 1'b0;
      peer_resolved_d    = 1'b0;
      arp_fail_d         = 1'b0;
      timer_load_c       = 1'b0;
      timer_en_c         = 1'b0;
      timer_load_value_c = REFRESH_INTERVAL - TIMER_W'(1);

      if (abort_c) begin
         retry_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!abort_c) begin
               if (ARPC_VALID) begin
                  state_d = ST_RESOLVED;
               end else if (!ARPC_ENABLE) begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            state_d = ST_GUARD;
            if (abort_c) abort_pend_d = 1'b1;
         end
         ST_GUARD: begin
            state_d = ST_WAIT;
            if (abort_c) abort_pend_d = 1'b1;
         end
         ST_WAIT: begin
            if (abort_c) abort_pend_d = 1'b1;
            if (!ARPC_ENABLE) begin
               // Transaction complete; an abort seen during it discards the result.
               abort_pend_d = 1'b0;
               if (discard_c) begin
                  state_d = ST_IDLE;
               end else if (ARPC_VALID) begin
                  state_d = ST_RESOLVED;
                  retry_d = '0;
               end else begin
                  retry_d = retry_inc_c;
                  state_d = (retry_inc_c == MAX_RETRY) ? ST_FAILED : ST_HOLDOFF;
               end
            end
         end
         ST_HOLDOFF: begin
            if (abort_c) begin
               state_d = ST_IDLE;
            end else if (timer_zero_c) begin
               state_d = ST_REQ;
            end
         end
         ST_RESOLVED: begin
            if (abort_c || !ARPC_VALID) begin
               state_d = ST_IDLE;
            end else if (REFRESH_EN && timer_zero_c) begin
               state_d = ST_REQ;
            end
         end
         ST_FAILED: begin
            if (abort_c) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      arpc_request_d = (state_d == ST_REQ);
      arp_fail_d     = (state_d == ST_FAILED);

      // During a refresh the peer MAC stays usable until the refresh fails.
      if (state_d == ST_RESOLVED) begin
         peer_resolved_d = 1'b1;
      end else if (REFRESH_EN && PEER_RESOLVED && !abort_c &&
                   (state_d inside {ST_REQ, ST_GUARD, ST_WAIT, ST_HOLDOFF})) begin
         peer_resolved_d = 1'b1;
      end

      // Timer loads on entry to HOLDOFF (and RESOLVED when refreshing).
      timer_load_c = (state_d != state_q) &&
                     ((state_d == ST_HOLDOFF) || (REFRESH_EN && (state_d == ST_RESOLVED)));
      if (state_d == ST_HOLDOFF) begin
         timer_load_value_c = RETRY_INTERVAL - TIMER_W'(1);
      end
      timer_en_c = (state_q == ST_HOLDOFF) || (state_q == ST_RESOLVED);
   end

   // State, sampled IP and registered outputs.
   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= ST_IDLE;
         ip_q          <= '0;
         abort_pend_q  <= 1'b0;
         retry_q       <= '0;
         ARPC_REQUEST  <= 1'b0;
         PEER_RESOLVED <= 1'b0;
         ARP_FAIL      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ip_q          <= PEER_IP_ADDRESS;
         abort_pend_q  <= abort_pend_d;
         retry_q       <= retry_d;
         ARPC_REQUEST  <= arpc_request_d;
         PEER_RESOLVED <= peer_resolved_d;
         ARP_FAIL      <= arp_fail_d;
      end
   end

   assign RETRY_COUNT = retry_q;
   assign SCHED_STATE = state_q;

endmodule

// File: tb/tb_aq_gemac_arp_sched.sv
// Self-checking bench for aq_gemac_arp_sched (RETRY_INTERVAL=16, MAX_RETRY=3,
// REFRESH_INTERVAL=64). Honours AQ_GEMAC_ARP_REFRESH_EN when defined.
module tb_aq_gemac_arp_sched;

   localparam int R = 16;
   localparam int M = 3;
   localparam int F = 64;

   logic        sys_clk = 1'b0;
   logic        RST_N = 1'b0;
   logic        ENABLE = 1'b0;
   logic [31:0] PEER_IP_ADDRESS = 32'hC0A8_001A;
   logic        ARPC_ENABLE = 1'b0;
   logic        ARPC_VALID = 1'b0;
   logic        ARPC_REQUEST;
   logic        PEER_RESOLVED;
   logic        ARP_FAIL;
   logic [3:0]  RETRY_COUNT;
   logic [2:0]  SCHED_STATE;

   aq_gemac_arp_sched #(
      .RETRY_INTERVAL   (32'd16),
      .MAX_RETRY        (4'd3),
      .REFRESH_INTERVAL (32'd64)
   ) dut (
      .sys_clk         (sys_clk),
      .RST_N           (RST_N),
      .ENABLE          (ENABLE),
      .PEER_IP_ADDRESS (PEER_IP_ADDRESS),
      .ARPC_ENABLE     (ARPC_ENABLE),
      .ARPC_VALID      (ARPC_VALID),
      .ARPC_REQUEST    (ARPC_REQUEST),
      .PEER_RESOLVED   (PEER_RESOLVED),
      .ARP_FAIL        (ARP_FAIL),
      .RETRY_COUNT     (RETRY_COUNT),
      .SCHED_STATE     (SCHED_STATE)
   );

   always #4 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ARP client model: per-request busy length and outcome.
   int rq_busy[$];
   bit rq_ok[$];
   int busy_left = 0;
   bit pend_ok = 1'b0;

   // Event logs (cycle numbers, sampled on the falling edge).
   int req_log[$];
   int res_rise[$];
   int res_fall[$];
   int fail_rise[$];
   bit prev_res = 1'b0;
   bit prev_fail = 1'b0;

   task automatic clear_logs();
      req_log.delete(); res_rise.delete(); res_fall.delete(); fail_rise.delete();
   endtask

   // One cycle: sample outputs, log events, run the client model.
   task automatic tick();
      @(negedge sys_clk);
      if (PEER_RESOLVED && !prev_res) res_rise.push_back(cyc);
      if (!PEER_RESOLVED && prev_res) res_fall.push_back(cyc);
      if (ARP_FAIL && !prev_fail) fail_rise.push_back(cyc);
      prev_res  = PEER_RESOLVED;
      prev_fail = ARP_FAIL;
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            ARPC_ENABLE = 1'b0;
            ARPC_VALID  = pend_ok;
         end
      end
      if (ARPC_REQUEST) begin
         req_log.push_back(cyc);
         if (rq_busy.size() > 0) begin
            busy_left = rq_busy.pop_front();
            pend_ok   = rq_ok.pop_front();
         end else begin
            busy_left = 5;
            pend_ok   = 1'b0;
         end
         ARPC_ENABLE = 1'b1;
         ARPC_VALID  = 1'b0;
      end
   endtask

   // Reference model: timeline of a resolution from the first request cycle.
   int pb[4];
   bit pok[4];
   int np;
   int exp_req[$];
   int exp_res;
   int exp_fail;
   int exp_retry;

   task automatic predict(input int t0);
      int t;
      int fails;
      t = t0;
      fails = 0;
      exp_req.delete();
      exp_res = -1;
      exp_fail = -1;
      exp_retry = 0;
      for (int k = 0; k < np; k++) begin
         int w;
         exp_req.push_back(t);
         w = t + ((pb[k] > 2) ? pb[k] : 2);
         if (pok[k]) begin
            exp_res = w + 1;
            exp_retry = 0;
            break;
         end
         fails++;
         exp_retry = fails;
         if (fails == M) begin
            exp_fail = w + 1;
            break;
         end
         t = w + R + 1;
      end
   endtask

   task automatic run_scenario(input string tag, input int extra);
      int last;
      clear_logs();
      rq_busy.delete(); rq_ok.delete();
      for (int k = 0; k < np; k++) begin
         rq_busy.push_back(pb[k]);
         rq_ok.push_back(pok[k]);
      end
      predict(cyc + 1);
      ENABLE = 1'b1;
      last = (exp_res >= 0) ? exp_res : exp_fail;
      while (cyc < last + extra) tick();
      check({tag, "_req_count"}, req_log.size(), exp_req.size());
      for (int k = 0; k < exp_req.size(); k++)
         if (k < req_log.size())
            check($sformatf("%s_req_time%0d", tag, k), req_log[k], exp_req[k]);
      check({tag, "_res_rise"}, (res_rise.size() > 0) ? res_rise[0] : -1, exp_res);
      check({tag, "_fail_rise"}, (fail_rise.size() > 0) ? fail_rise[0] : -1, exp_fail);
      check({tag, "_retry"}, RETRY_COUNT, exp_retry);
      check({tag, "_resolved"}, PEER_RESOLVED, (exp_res >= 0));
      check({tag, "_arp_fail"}, ARP_FAIL, (exp_fail >= 0));
   endtask

   task automatic end_scenario(input string tag);
      ENABLE = 1'b0;
      ARPC_VALID = 1'b0;
      repeat (3) tick();
      check({tag, "_end_state"}, SCHED_STATE, 0);
      check({tag, "_end_retry"}, RETRY_COUNT, 0);
      check({tag, "_end_fail"}, ARP_FAIL, 0);
      check({tag, "_end_res"}, PEER_RESOLVED, 0);
   endtask

   typedef struct {
      int busy;
      int nfail;
      int exp_nreq;
      bit exp_res;
      bit exp_fail;
      int exp_retry;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int s;
      int t;
      int lows;
      int r1, r2, r3, r4, w4;

      tbl[0] = '{busy: 5, nfail: 0, exp_nreq: 1, exp_res: 1, exp_fail: 0, exp_retry: 0};
      tbl[1] = '{busy: 2, nfail: 1, exp_nreq: 2, exp_res: 1, exp_fail: 0, exp_retry: 0};
      tbl[2] = '{busy: 1, nfail: 2, exp_nreq: 3, exp_res: 1, exp_fail: 0, exp_retry: 0};
      tbl[3] = '{busy: 3, nfail: 3, exp_nreq: 3, exp_res: 0, exp_fail: 1, exp_retry: 3};
      tbl[4] = '{busy: 7, nfail: 1, exp_nreq: 2, exp_res: 1, exp_fail: 0, exp_retry: 0};

      // Reset values, both during and after reset.
      repeat (3) @(negedge sys_clk);
      check("rst_req", ARPC_REQUEST, 0);
      check("rst_res", PEER_RESOLVED, 0);
      RST_N = 1'b1;
      repeat (4) tick();
      check("reset_req", ARPC_REQUEST, 0);
      check("reset_res", PEER_RESOLVED, 0);
      check("reset_fail", ARP_FAIL, 0);
      check("reset_retry", RETRY_COUNT, 0);
      check("reset_state", SCHED_STATE, 0);

      // Directed table: outcomes with known request counts and final status.
      for (int i = 0; i < 5; i++) begin
         string tag;
         tag = $sformatf("tbl%0d", i);
         np = M;
         for (int k = 0; k < M; k++) begin
            pb[k]  = tbl[i].busy;
            pok[k] = (k == tbl[i].nfail);
         end
         run_scenario(tag, tbl[i].exp_fail ? 200 : 20);
         check({tag, "_nreq_tbl"}, req_log.size(), tbl[i].exp_nreq);
         check({tag, "_res_tbl"}, PEER_RESOLVED, tbl[i].exp_res);
         check({tag, "_fail_tbl"}, ARP_FAIL, tbl[i].exp_fail);
         check({tag, "_retry_tbl"}, RETRY_COUNT, tbl[i].exp_retry);
         end_scenario(tag);
      end

      // Randomized client latencies and outcomes against the model.
      for (int i = 0; i < 15; i++) begin
         string tag;
         tag = $sformatf("rnd%0d", i);
         np = M;
         for (int k = 0; k < M; k++) begin
            pb[k]  = int'($urandom_range(1, 8));
            pok[k] = ($urandom_range(0, 2) == 0);
         end
         run_scenario(tag, 20);
         end_scenario(tag);
      end

      // IP change while FAILED clears ARP_FAIL and restarts quickly.
      np = M;
      for (int k = 0; k < M; k++) begin pb[k] = 2; pok[k] = 1'b0; end
      run_scenario("t3", 10);
      clear_logs();
      rq_busy.push_back(2); rq_ok.push_back(1'b1);
      PEER_IP_ADDRESS = 32'hC0A8_001B;
      s = cyc;
      tick();
      check("t3_fail_clr", ARP_FAIL, 0);
      check("t3_retry_clr", RETRY_COUNT, 0);
      repeat (2) tick();
      check("t3_req_count", req_log.size(), 1);
      check("t3_req_time", (req_log.size() > 0) ? req_log[0] : -1, s + 2);
      repeat (8) tick();
      check("t3_resolved", PEER_RESOLVED, 1);
      end_scenario("t3");

      // IP change coincides with ARPC_VALID in WAIT: result discarded.
      clear_logs();
      rq_busy.delete(); rq_ok.delete();
      rq_busy.push_back(5); rq_ok.push_back(1'b1);
      rq_busy.push_back(2); rq_ok.push_back(1'b1);
      s = cyc;
      ENABLE = 1'b1;
      t = s + 1;
      while (cyc < t + 5) tick();
      PEER_IP_ADDRESS = 32'hC0A8_0020;
      tick();
      check("t4_no_resolve", PEER_RESOLVED, 0);
      ARPC_VALID = 1'b0;
      tick();
      check("t4_no_resolve2", PEER_RESOLVED, 0);
      check("t4_req_count", req_log.size(), 2);
      check("t4_req_time", (req_log.size() > 1) ? req_log[1] : -1, t + 7);
      repeat (5) tick();
      check("t4_resolved", PEER_RESOLVED, 1);
      end_scenario("t4");

      // ENABLE dropped mid-HOLDOFF.
      clear_logs();
      rq_busy.delete(); rq_ok.delete();
      rq_busy.push_back(3); rq_ok.push_back(1'b0);
      s = cyc;
      ENABLE = 1'b1;
      t = s + 1;
      while (cyc < t + 10) tick();
      check("t5_retry_before", RETRY_COUNT, 1);
      ENABLE = 1'b0;
      tick();
      check("t5_state_idle", SCHED_STATE, 0);
      check("t5_retry_clr", RETRY_COUNT, 0);
      clear_logs();
      repeat (30) tick();
      check("t5_no_req", req_log.size(), 0);
      rq_busy.push_back(2); rq_ok.push_back(1'b1);
      s = cyc;
      ENABLE = 1'b1;
      tick();
      check("t5_req_time", (req_log.size() > 0) ? req_log[0] : -1, s + 1);
      repeat (6) tick();
      end_scenario("t5");

`ifdef AQ_GEMAC_ARP_REFRESH_EN
      // Periodic refresh, then a refresh that exhausts its retries.
      np = 1; pb[0] = 2; pok[0] = 1'b1;
      run_scenario("t6", 2);
      rq_busy.push_back(3); rq_ok.push_back(1'b1);
      for (int k = 0; k < M; k++) begin rq_busy.push_back(3); rq_ok.push_back(1'b0); end
      r1 = exp_res + F;
      r2 = (r1 + 3) + 1 + F;
      r3 = (r2 + 3) + R + 1;
      r4 = (r3 + 3) + R + 1;
      w4 = r4 + 3;
      clear_logs();
      lows = 0;
      while (cyc < w4 + 10) begin
         tick();
         if (cyc <= w4 && !PEER_RESOLVED) lows++;
      end
      check("t6_res_held", lows, 0);
      check("t6_req_count", req_log.size(), 4);
      check("t6_req1", (req_log.size() > 0) ? req_log[0] : -1, r1);
      check("t6_req2", (req_log.size() > 1) ? req_log[1] : -1, r2);
      check("t6_req3", (req_log.size() > 2) ? req_log[2] : -1, r3);
      check("t6_req4", (req_log.size() > 3) ? req_log[3] : -1, r4);
      check("t6_fail_rise", (fail_rise.size() > 0) ? fail_rise[0] : -1, w4 + 1);
      check("t6_res_fall", (res_fall.size() > 0) ? res_fall[0] : -1, w4 + 1);
      end_scenario("t6");
`else
      // Without refresh, RESOLVED is held with no further requests.
      np = 1; pb[0] = 2; pok[0] = 1'b1;
      run_scenario("t6", 2);
      clear_logs();
      lows = 0;
      repeat (150) begin
         tick();
         if (!PEER_RESOLVED) lows++;
      end
      check("t6_no_refresh", req_log.size(), 0);
      check("t6_res_held", lows, 0);
      end_scenario("t6");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute bound on the run.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
